// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage hazard scoreboard with per-register pending counts
// and shared multiplier occupancy tracking
typedef struct packed {
    logic dep_src2;
    logic dep_src1;
} bypass_t;

module hazard_scoreboard #(
    parameter int REG_FILE_LEN = 32,
    parameter int MUL_LATENCY  = 4,
    parameter int CNT_W        = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dec_valid,
    input  logic [$clog2(REG_FILE_LEN)-1:0] dec_src1,
    input  logic [$clog2(REG_FILE_LEN)-1:0] dec_src2,
    input  logic                            dec_uses_src1,
    input  logic                            dec_uses_src2,
    input  logic [$clog2(REG_FILE_LEN)-1:0] dec_dst,
    input  logic                            dec_wen,
    input  logic                            dec_is_mul,
    input  logic                            exe_valid,
    input  logic                            exe_wen,
    input  logic                            exe_ready,
    input  logic [$clog2(REG_FILE_LEN)-1:0] exe_dst,
    input  logic                            mem_valid,
    input  logic                            mem_wen,
    input  logic                            mem_ready,
    input  logic [$clog2(REG_FILE_LEN)-1:0] mem_dst,
    input  logic                            mem_stall,
    input  logic                            wb_valid,
    input  logic                            wb_wen,
    input  logic [$clog2(REG_FILE_LEN)-1:0] wb_dst,
    output logic                            stall_dec,
    output logic                            issue,
    output bypass_t                         exe_bypass,
    output bypass_t                         mem_bypass,
    output logic                            mul_busy,
    output logic [REG_FILE_LEN-1:0]         pending
);
    localparam int               IDX_W   = $clog2(REG_FILE_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       MUL_LAT = 4'(MUL_LATENCY);

    logic [CNT_W-1:0] cnt_q [REG_FILE_LEN];
    logic [CNT_W-1:0] cnt_d [REG_FILE_LEN];
    logic [3:0]       mul_cnt_q, mul_cnt_d;
    logic [IDX_W-1:0] mul_dst_q, mul_dst_d;

    logic s1_used, s2_used;
    logic exe_hit1, exe_hit2, mem_hit1, mem_hit2;
    logic raw1, raw2, wb_raw1, wb_raw2;
    logic struct_haz, waw_haz, sat_haz, hazard;
    logic mul_active, issue_int, inc_en, dec_en;

    always_comb begin
        s1_used  = dec_uses_src1 & (dec_src1 != '0);
        s2_used  = dec_uses_src2 & (dec_src2 != '0);
        exe_hit1 = s1_used & exe_valid & exe_wen & (exe_dst == dec_src1);
        exe_hit2 = s2_used & exe_valid & exe_wen & (exe_dst == dec_src2);
        // EXE holds the youngest producer, so it shadows any MEM match
        mem_hit1 = s1_used & mem_valid & mem_wen & (mem_dst == dec_src1) & ~exe_hit1;
        mem_hit2 = s2_used & mem_valid & mem_wen & (mem_dst == dec_src2) & ~exe_hit2;

        raw1 = s1_used & (cnt_q[dec_src1] != '0)
             & ~((exe_hit1 & exe_ready) | (mem_hit1 & mem_ready));
        raw2 = s2_used & (cnt_q[dec_src2] != '0)
             & ~((exe_hit2 & exe_ready) | (mem_hit2 & mem_ready));
        // register file write lands at the end of this cycle, too late for decode read
        wb_raw1 = s1_used & wb_valid & wb_wen & (wb_dst == dec_src1) & ~exe_hit1 & ~mem_hit1;
        wb_raw2 = s2_used & wb_valid & wb_wen & (wb_dst == dec_src2) & ~exe_hit2 & ~mem_hit2;

        mul_active = (mul_cnt_q != '0);
        struct_haz = dec_is_mul & mul_active;
        waw_haz    = dec_wen & (dec_dst != '0) & mul_active & (mul_dst_q == dec_dst);
        sat_haz    = dec_wen & (dec_dst != '0) & (cnt_q[dec_dst] == CNT_MAX);
        hazard     = raw1 | raw2 | wb_raw1 | wb_raw2 | struct_haz | waw_haz | sat_haz | mem_stall;

        issue_int = dec_valid & ~hazard;
        inc_en    = issue_int & dec_wen & (dec_dst != '0);
        dec_en    = wb_valid & wb_wen & (wb_dst != '0);
    end

    always_comb begin
        stall_dec           = ~rst & dec_valid & hazard;
        issue               = ~rst & issue_int;
        exe_bypass.dep_src1 = ~rst & exe_hit1;
        exe_bypass.dep_src2 = ~rst & exe_hit2;
        mem_bypass.dep_src1 = ~rst & mem_hit1;
        mem_bypass.dep_src2 = ~rst & mem_hit2;
        mul_busy            = ~rst & mul_active;
        pending             = '0;
        for (int r = 0; r < REG_FILE_LEN; r++) begin
            pending[r] = ~rst & (cnt_q[r] != '0);
        end
    end

    always_comb begin
        for (int r = 0; r < REG_FILE_LEN; r++) begin
            logic inc_r, dec_r;
            inc_r    = inc_en & (dec_dst == IDX_W'(r));
            dec_r    = dec_en & (wb_dst == IDX_W'(r));
            cnt_d[r] = cnt_q[r];
            if (inc_r & ~dec_r) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_r & ~inc_r & (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end

        mul_cnt_d = mul_cnt_q;
        mul_dst_d = mul_dst_q;
        if (issue_int & dec_is_mul) begin
            mul_cnt_d = MUL_LAT;
            mul_dst_d = dec_dst;
        end else if (mul_active) begin
            mul_cnt_d = mul_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_FILE_LEN; r++) begin
                cnt_q[r] <= '0;
            end
            mul_cnt_q <= '0;
            mul_dst_q <= '0;
        end else begin
            for (int r = 0; r < REG_FILE_LEN; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            mul_cnt_q <= mul_cnt_d;
            mul_dst_q <= mul_dst_d;
        end
    end

    // a writeback for a register with nothing outstanding means the pipeline lost track
    always_ff @(posedge clk) begin
        if (!rst && dec_en) begin
            assert (cnt_q[wb_dst] != '0);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard
// against a behavioural pending-count model
module tb_hazard_scoreboard;
    localparam int NREG  = 32;
    localparam int LAT   = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic dec_valid, dec_uses_src1, dec_uses_src2, dec_wen, dec_is_mul;
    logic [4:0] dec_src1, dec_src2, dec_dst, exe_dst, mem_dst, wb_dst;
    logic exe_valid, exe_wen, exe_ready, mem_valid, mem_wen, mem_ready, mem_stall;
    logic wb_valid, wb_wen;
    logic stall_dec, issue, mul_busy;
    logic [1:0] exe_bypass, mem_bypass;
    logic [NREG-1:0] pending;

    int checks = 0;
    int failures = 0;

    int m_cnt [NREG];
    int m_mul;
    int m_mul_dst;
    logic e_stall, e_issue, e_busy;
    logic [1:0] e_exb, e_meb;
    logic [NREG-1:0] e_pend;

    hazard_scoreboard #(.REG_FILE_LEN(NREG), .MUL_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src2(dec_src2),
        .dec_uses_src1(dec_uses_src1), .dec_uses_src2(dec_uses_src2),
        .dec_dst(dec_dst), .dec_wen(dec_wen), .dec_is_mul(dec_is_mul),
        .exe_valid(exe_valid), .exe_wen(exe_wen), .exe_ready(exe_ready), .exe_dst(exe_dst),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_ready(mem_ready), .mem_dst(mem_dst),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_dst(wb_dst),
        .stall_dec(stall_dec), .issue(issue), .exe_bypass(exe_bypass), .mem_bypass(mem_bypass),
        .mul_busy(mul_busy), .pending(pending)
    );

    always #5 clk = ~clk;

    // Operand availability: a source is fine if nothing is outstanding for it, or if
    // the youngest in-flight producer can forward a ready value.
    task automatic model_eval();
        logic hz;
        hz = 1'b0;
        e_exb = 2'b00;
        e_meb = 2'b00;
        for (int k = 0; k < 2; k++) begin
            int src;
            bit used, in_exe, in_mem, fwd;
            src    = (k == 0) ? int'(dec_src1) : int'(dec_src2);
            used   = ((k == 0) ? dec_uses_src1 : dec_uses_src2) && src != 0;
            in_exe = used && exe_valid && exe_wen && int'(exe_dst) == src;
            in_mem = used && !in_exe && mem_valid && mem_wen && int'(mem_dst) == src;
            fwd    = (in_exe && exe_ready) || (in_mem && mem_ready);
            e_exb[k] = in_exe;
            e_meb[k] = in_mem;
            if (used && m_cnt[src] > 0 && !fwd) hz = 1'b1;
            if (used && !in_exe && !in_mem && wb_valid && wb_wen && int'(wb_dst) == src) hz = 1'b1;
        end
        if (dec_is_mul && m_mul > 0) hz = 1'b1;
        if (dec_wen && dec_dst != 0 && m_mul > 0 && m_mul_dst == int'(dec_dst)) hz = 1'b1;
        if (dec_wen && dec_dst != 0 && m_cnt[dec_dst] == CMAX) hz = 1'b1;
        if (mem_stall) hz = 1'b1;
        e_stall = !rst && dec_valid && hz;
        e_issue = !rst && dec_valid && !hz;
        e_busy  = !rst && m_mul > 0;
        if (rst) begin
            e_exb = 2'b00;
            e_meb = 2'b00;
        end
        for (int r = 0; r < NREG; r++) e_pend[r] = !rst && m_cnt[r] > 0;
    endtask

    task automatic tick();
        bit inc, dcr;
        model_eval();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
            m_mul = 0;
        end else begin
            inc = e_issue && dec_wen && dec_dst != 0;
            dcr = wb_valid && wb_wen && wb_dst != 0;
            if (!(inc && dcr && dec_dst == wb_dst)) begin
                if (inc) m_cnt[dec_dst]++;
                if (dcr && m_cnt[wb_dst] > 0) m_cnt[wb_dst]--;
            end
            if (e_issue && dec_is_mul) begin
                m_mul = LAT;
                m_mul_dst = int'(dec_dst);
            end else if (m_mul > 0) begin
                m_mul--;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; dec_valid = 0; dec_uses_src1 = 0; dec_uses_src2 = 0; dec_wen = 0; dec_is_mul = 0;
        dec_src1 = 0; dec_src2 = 0; dec_dst = 0;
        exe_valid = 0; exe_wen = 0; exe_ready = 0; exe_dst = 0;
        mem_valid = 0; mem_wen = 0; mem_ready = 0; mem_dst = 0; mem_stall = 0;
        wb_valid = 0; wb_wen = 0; wb_dst = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        idle();
    endtask

    task automatic set_dec(input logic [4:0] dst, input logic mul);
        dec_valid = 1; dec_wen = 1; dec_dst = dst; dec_is_mul = mul;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; set_dec(5'd5, 1'b1); dec_uses_src1 = 1; dec_src1 = 5;
        exe_valid = 1; exe_wen = 1; exe_dst = 5; mem_valid = 1; mem_wen = 1; mem_dst = 5;
        #2;
        checks++;
        if ({stall_dec, issue, exe_bypass, mem_bypass, mul_busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", {stall_dec, issue, exe_bypass, mem_bypass, mul_busy}, 7'b0);
        end
        checks++;
        if (pending !== '0) begin
            failures++;
            $display("FAIL reset_pending got=%h exp=0", pending);
        end
        tick();
        tick();
        idle();
        #2;
        checks++;
        if ({mul_busy, pending} !== '0) begin
            failures++;
            $display("FAIL reset_state got busy=%b pending=%h exp busy=0 pending=0", mul_busy, pending);
        end
        tick();
    endtask

    task automatic test_pending();
        do_reset();
        set_dec(5'd5, 1'b0);
        #2;
        checks++;
        if ({stall_dec, issue} !== 2'b01) begin
            failures++;
            $display("FAIL pend_issue got=%b exp=01", {stall_dec, issue});
        end
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin wb_valid = 1; wb_wen = 1; wb_dst = 5; end
            #2;
            checks++;
            if (pending !== (32'd1 << 5)) begin
                failures++;
                $display("FAIL pend_held cycle=%0d got=%h exp=%h", i, pending, 32'd1 << 5);
            end
            tick();
            idle();
        end
        #2;
        checks++;
        if (pending !== '0) begin
            failures++;
            $display("FAIL pend_cleared got=%h exp=0", pending);
        end
        tick();
        set_dec(5'd6, 1'b1);
        tick();
        idle();
        #2;
        checks++;
        if ({mul_busy, pending} !== {1'b1, 32'd1 << 6}) begin
            failures++;
            $display("FAIL pend_mul_started got busy=%b pending=%h exp busy=1 pending=%h", mul_busy, pending, 32'd1 << 6);
        end
        rst = 1;
        #1;
        checks++;
        if ({mul_busy, pending} !== '0) begin
            failures++;
            $display("FAIL mid_reset_forced got busy=%b pending=%h exp 0", mul_busy, pending);
        end
        tick();
        rst = 0;
        #2;
        checks++;
        if ({mul_busy, pending} !== '0) begin
            failures++;
            $display("FAIL mid_reset_cleared got busy=%b pending=%h exp 0", mul_busy, pending);
        end
        tick();
    endtask

    task automatic test_exe_bypass();
        do_reset();
        set_dec(5'd3, 1'b0);
        tick();
        idle();
        exe_valid = 1; exe_wen = 1; exe_dst = 3; exe_ready = 1;
        set_dec(5'd4, 1'b0);
        dec_uses_src1 = 1; dec_uses_src2 = 1; dec_src1 = 3; dec_src2 = 3;
        #2;
        checks++;
        if ({stall_dec, issue, exe_bypass, mem_bypass} !== 6'b01_11_00) begin
            failures++;
            $display("FAIL exe_bypass got=%b exp=%b", {stall_dec, issue, exe_bypass, mem_bypass}, 6'b01_11_00);
        end
        tick();
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        set_dec(5'd7, 1'b0);
        tick();
        idle();
        exe_valid = 1; exe_wen = 1; exe_dst = 7; exe_ready = 0;
        set_dec(5'd8, 1'b0); dec_uses_src1 = 1; dec_src1 = 7;
        #2;
        checks++;
        if ({stall_dec, issue, exe_bypass, mem_bypass} !== 6'b10_01_00) begin
            failures++;
            $display("FAIL load_use_stall got=%b exp=%b", {stall_dec, issue, exe_bypass, mem_bypass}, 6'b10_01_00);
        end
        tick();
        exe_valid = 0; exe_wen = 0;
        mem_valid = 1; mem_wen = 1; mem_dst = 7; mem_ready = 1;
        #2;
        checks++;
        if ({stall_dec, issue, exe_bypass, mem_bypass} !== 6'b01_00_01) begin
            failures++;
            $display("FAIL load_use_mem_fwd got=%b exp=%b", {stall_dec, issue, exe_bypass, mem_bypass}, 6'b01_00_01);
        end
        tick();
        idle();
    endtask

    task automatic test_mul();
        do_reset();
        set_dec(5'd9, 1'b1);
        tick();
        for (int i = 0; i < LAT; i++) begin
            #2;
            checks++;
            if ({mul_busy, stall_dec, issue} !== 3'b110) begin
                failures++;
                $display("FAIL mul_struct cycle=%0d got=%b exp=110", i, {mul_busy, stall_dec, issue});
            end
            tick();
        end
        #2;
        checks++;
        if ({mul_busy, stall_dec, issue} !== 3'b001) begin
            failures++;
            $display("FAIL mul_second_issue got=%b exp=001", {mul_busy, stall_dec, issue});
        end
        tick();
        set_dec(5'd10, 1'b0);
        #2;
        checks++;
        if ({mul_busy, stall_dec, issue} !== 3'b101) begin
            failures++;
            $display("FAIL mul_indep_add got=%b exp=101", {mul_busy, stall_dec, issue});
        end
        tick();
        set_dec(5'd9, 1'b0);
        for (int i = 0; i < LAT - 1; i++) begin
            #2;
            checks++;
            if ({mul_busy, stall_dec, issue} !== 3'b110) begin
                failures++;
                $display("FAIL mul_waw cycle=%0d got=%b exp=110", i, {mul_busy, stall_dec, issue});
            end
            tick();
        end
        #2;
        checks++;
        if ({mul_busy, stall_dec, issue} !== 3'b001) begin
            failures++;
            $display("FAIL mul_waw_release got=%b exp=001", {mul_busy, stall_dec, issue});
        end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        set_dec(5'd2, 1'b0);
        for (int i = 0; i < CMAX; i++) begin
            #2;
            checks++;
            if (issue !== 1'b1) begin
                failures++;
                $display("FAIL sat_fill n=%0d got issue=%b exp=1", i, issue);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin wb_valid = 1; wb_wen = 1; wb_dst = 2; end
            #2;
            checks++;
            if ({stall_dec, issue, pending[2]} !== 3'b101) begin
                failures++;
                $display("FAIL sat_stall n=%0d got=%b exp=101", i, {stall_dec, issue, pending[2]});
            end
            tick();
        end
        wb_valid = 1; wb_wen = 1; wb_dst = 2;
        #2;
        checks++;
        if (issue !== 1'b1) begin
            failures++;
            $display("FAIL sat_issue_with_wb got issue=%b exp=1", issue);
        end
        tick();
        wb_valid = 0; wb_wen = 0;
        #2;
        checks++;
        if (issue !== 1'b1) begin
            failures++;
            $display("FAIL sat_refill got issue=%b exp=1", issue);
        end
        tick();
        #2;
        checks++;
        if ({stall_dec, issue} !== 2'b10) begin
            failures++;
            $display("FAIL sat_restall got=%b exp=10", {stall_dec, issue});
        end
        tick();
        idle();
    endtask

    task automatic test_x0_memstall();
        do_reset();
        exe_valid = 1; exe_wen = 1; mem_valid = 1; mem_wen = 1; wb_valid = 1; wb_wen = 1;
        set_dec(5'd0, 1'b0); dec_uses_src1 = 1; dec_uses_src2 = 1;
        #2;
        checks++;
        if ({stall_dec, issue, exe_bypass, mem_bypass} !== 6'b01_00_00) begin
            failures++;
            $display("FAIL x0_no_hazard got=%b exp=%b", {stall_dec, issue, exe_bypass, mem_bypass}, 6'b01_00_00);
        end
        tick();
        idle();
        set_dec(5'd12, 1'b1);
        tick();
        idle();
        set_dec(5'd13, 1'b0);
        mem_stall = 1;
        for (int i = 0; i < LAT; i++) begin
            #2;
            checks++;
            if ({mul_busy, stall_dec, issue} !== 3'b110) begin
                failures++;
                $display("FAIL memstall cycle=%0d got=%b exp=110", i, {mul_busy, stall_dec, issue});
            end
            tick();
        end
        #2;
        checks++;
        if ({mul_busy, stall_dec, issue, pending} !== {3'b010, 32'd1 << 12}) begin
            failures++;
            $display("FAIL memstall_mul_drain got=%b pending=%h exp=010 pending=%h", {mul_busy, stall_dec, issue}, pending, 32'd1 << 12);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            dec_valid = $urandom_range(0, 3) != 0;
            dec_uses_src1 = $urandom_range(0, 1); dec_uses_src2 = $urandom_range(0, 1);
            dec_src1 = 5'($urandom_range(0, 3)); dec_src2 = 5'($urandom_range(0, 3));
            dec_dst = 5'($urandom_range(0, 3)); dec_wen = $urandom_range(0, 1);
            dec_is_mul = ($urandom_range(0, 3) == 0);
            exe_valid = $urandom_range(0, 1); exe_wen = $urandom_range(0, 1);
            exe_ready = $urandom_range(0, 1); exe_dst = 5'($urandom_range(0, 3));
            mem_valid = $urandom_range(0, 1); mem_wen = $urandom_range(0, 1);
            mem_ready = $urandom_range(0, 1); mem_dst = 5'($urandom_range(0, 3));
            mem_stall = ($urandom_range(0, 7) == 0);
            wb_valid = $urandom_range(0, 1); wb_dst = 5'($urandom_range(0, 3));
            wb_wen = $urandom_range(0, 1) && (wb_dst == 0 || m_cnt[wb_dst] > 0);
            #2;
            model_eval();
            checks++;
            if ({stall_dec, issue, exe_bypass, mem_bypass, mul_busy} !== {e_stall, e_issue, e_exb, e_meb, e_busy}) begin
                failures++;
                $display("FAIL rand_outputs n=%0d got=%b exp=%b", n,
                         {stall_dec, issue, exe_bypass, mem_bypass, mul_busy}, {e_stall, e_issue, e_exb, e_meb, e_busy});
            end
            checks++;
            if (pending !== e_pend) begin
                failures++;
                $display("FAIL rand_pending n=%0d got=%h exp=%h", n, pending, e_pend);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_mul = 0;
        m_mul_dst = 0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_pending();
        test_exe_bypass();
        test_load_use();
        test_mul();
        test_saturation();
        test_x0_memstall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
